gpio_cmd_ctrl: RTL and testbench
================================

# gpio_cmd_ctrl

Parametrised GPIO command controller between the soft processor's 32-bit GPO/GPI register pair and the modem datapath (Tx/Rx enables, phase select, log BRAM, per-channel BER counters). It supersedes the fixed I/Q command decoder with a channel-indexed command set, configurable field widths and memory latency, and a one-deep pending-command buffer. It also adds error reporting and a status word. It sits in `top`, clocked by `clk100`.

## Interface
- `NB_GPIOS`, 32: GPO/GPI width; command field is bits [NB_GPIOS-1 -: 8], enable is bit NB_GPIOS-9, data is bits [NB_GPIOS-10:0].
- `N_CH`, 2: number of BER channels (0 = I, 1 = Q, further channels allowed).
- `NB_BER`, 64: BER counter width; must be ≤ 2·NB_GPIOS.
- `NB_PHASE`, 2: phase-select width.
- `BRAM_ADDR_WIDTH`, 15; `BRAM_DATA_WIDTH`, 16 (must be ≤ NB_GPIOS).
- `MEM_LAT`, 2: BRAM read latency in cycles, ≥1.
- `RST_LEN`, 4: soft-reset pulse length in cycles, ≥1.

Ports:
- `clk100` in 1: single clock.
- `i_resetn` in 1: reset, asynchronous, active-low.
- `i_gpo` in NB_GPIOS: command word from processor.
- `o_gpi` out NB_GPIOS: response word.
- `o_rst` out 1: datapath soft reset.
- `o_en_tx`, `o_en_rx` out 1: Tx/Rx enables.
- `o_phase_sel` out NB_PHASE: filter phase.
- `o_run_log` out 1: one-cycle log start pulse.
- `o_read_log` out 1: memory read mode.
- `o_addr_log` out BRAM_ADDR_WIDTH: read address.
- `i_mem_full` in 1: log memory full.
- `i_mem_data` in BRAM_DATA_WIDTH: BRAM read data.
- `i_ber_samples`, `i_ber_errors` in N_CH·NB_BER: channel c occupies bits [c·NB_BER +: NB_BER].
- `o_cmd_err` out 1: last command illegal or dropped.

## Operation
- The enable bit passes a 2-flop synchronizer and then a rising-edge detector. The command and data fields are captured in the detect cycle E. Software holds the fields stable while the enable is high.
- Command codes:
  - RESET=0: `o_rst` high for RST_LEN cycles. Clears en_tx, en_rx, read_log and the pending slot. Phase is kept.
  - EN_TX=1: en_tx ← d[0].
  - EN_RX=2: en_rx ← d[0].
  - PH_SEL=3: phase ← d[NB_PHASE-1:0].
  - RUN_MEM=4: one-cycle `o_run_log` pulse; read_log ← 0.
  - READ_MEM=5: read_log ← d[0].
  - ADDR_MEM=6: addr ← d[BRAM_ADDR_WIDTH-1:0]. If read_log=1, perform a BRAM read; otherwise error.
  - BER_S=7 / BER_E=8, channel c = d[7:0]: capture the NB_BER-bit counter into the shadow register; o_gpi ← shadow[NB_GPIOS-1:0].
  - BER_H=9: o_gpi ← shadow[NB_BER-1:NB_GPIOS], zero-extended.
  - IS_MEM_FULL=10: o_gpi ← {0, i_mem_full}.
  - STATUS=11: o_gpi ← {0, i_mem_full, read_log, en_rx, en_tx, cmd_err}.
- Illegal command (code >11, c ≥ N_CH, or ADDR_MEM with read_log=0): o_gpi ← 0 and o_cmd_err ← 1. A legal command clears o_cmd_err, except that STATUS reports the flag before clearing it.
- FSM:
  - IDLE → EXEC on an edge.
  - EXEC → MEM_WAIT for an ADDR_MEM read; otherwise → IDLE.
  - MEM_WAIT counts MEM_LAT cycles → RESP.
  - RESP: o_gpi ← zero-extended i_mem_data → IDLE, or → EXEC if a command is pending.
- An edge arriving in MEM_WAIT/RESP is stored in the one-deep pending slot. A further edge while the slot is full is dropped and sets o_cmd_err.

## Timing
- Reset values: o_gpi=0, o_rst=0, en_tx=en_rx=0, phase=0, run_log=0, read_log=0, addr=0, cmd_err=0, state IDLE, pending empty, shadow 0.
- Control outputs and register-read o_gpi update at E+1.
- Memory reads: o_addr_log valid at E+1; o_gpi updates at E+2+MEM_LAT.
- A pending command executes the cycle after RESP.
- Asserting i_resetn low mid-read aborts immediately to reset values.
- A RESET command issued during an `o_rst` pulse restarts the count.

## Configuration
- `GPIO_CMD_SNAPSHOT_EN` defined: BER_S captures samples and errors of channel c in the same cycle. The following BER_E for the same c returns the snapshot errors, so both values are coherent.
- Undefined: BER_E captures the live error counter at its own E.

## Structure
- `gpio_cmd_pkg` holds the command code localparams, FSM state enum and field-position constants.
- Sub-module `gpio_edge_sync` implements the 2-flop synchronizer plus rising-edge pulse.

## Test plan
- Reset, then STATUS → o_gpi=0. Then EN_TX d=1, EN_RX d=1, STATUS → o_gpi=0x6.
- PH_SEL d=3, then d=1 → o_phase_sel=3 at E+1, then 1. RESET → o_rst high exactly 4 cycles, enables 0, phase stays 1.
- i_ber_samples ch1=0x0000_0002_0000_0005; BER_S c=1 → o_gpi=0x5; BER_H → 0x2. BER_S c=2 → o_gpi=0, o_cmd_err=1.
- READ_MEM d=1, ADDR_MEM d=0x2A9C with BRAM model returning addr^0xFFFF → o_gpi=0xD563 at E+4. ADDR_MEM with read_log=0 → cmd_err=1.
- Two edges during MEM_WAIT → first executes after RESP, second dropped with cmd_err=1. i_resetn low in MEM_WAIT → all outputs 0.
- With `GPIO_CMD_SNAPSHOT_EN`: BER_S c=0, change errors, BER_E c=0 → old value. Without the macro → new value.

Source files
------------

// File: rtl/gpio_cmd_pkg.sv
// gpio_cmd_pkg: command codes, FSM states and GPO field layout shared by gpio_cmd_ctrl
package gpio_cmd_pkg;
  localparam int CMD_W = 8;
  localparam int CH_W = 8;
  localparam logic [CMD_W-1:0] CMD_RESET       = 8'd0;
  localparam logic [CMD_W-1:0] CMD_EN_TX       = 8'd1;
  localparam logic [CMD_W-1:0] CMD_EN_RX       = 8'd2;
  localparam logic [CMD_W-1:0] CMD_PH_SEL      = 8'd3;
  localparam logic [CMD_W-1:0] CMD_RUN_MEM     = 8'd4;
  localparam logic [CMD_W-1:0] CMD_READ_MEM    = 8'd5;
  localparam logic [CMD_W-1:0] CMD_ADDR_MEM    = 8'd6;
  localparam logic [CMD_W-1:0] CMD_BER_S       = 8'd7;
  localparam logic [CMD_W-1:0] CMD_BER_E       = 8'd8;
  localparam logic [CMD_W-1:0] CMD_BER_H       = 8'd9;
  localparam logic [CMD_W-1:0] CMD_IS_MEM_FULL = 8'd10;
  localparam logic [CMD_W-1:0] CMD_STATUS      = 8'd11;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MEM_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/gpio_edge_sync.sv
// gpio_edge_sync: two-flop synchroniser on d with a one-cycle pulse on its rising edge
module gpio_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[1:0], d};
  assign pulse = s[1] & ~s[2];
endmodule

// File: rtl/gpio_cmd_ctrl.sv
// gpio_cmd_ctrl: GPO/GPI command controller for the modem datapath (enables, phase, log BRAM, BER readout); GPIO_CMD_SNAPSHOT_EN makes BER_S also snapshot the error counter
module gpio_cmd_ctrl
  import gpio_cmd_pkg::*;
#(
  parameter int NB_GPIOS = 32,
  parameter int N_CH = 2,
  parameter int NB_BER = 64,
  parameter int NB_PHASE = 2,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 16,
  parameter int MEM_LAT = 2,
  parameter int RST_LEN = 4
) (
  input  logic                       clk100,
  input  logic                       i_resetn,
  input  logic [NB_GPIOS-1:0]        i_gpo,
  output logic [NB_GPIOS-1:0]        o_gpi,
  output logic                       o_rst,
  output logic                       o_en_tx,
  output logic                       o_en_rx,
  output logic [NB_PHASE-1:0]        o_phase_sel,
  output logic                       o_run_log,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
  input  logic                       i_mem_full,
  input  logic [BRAM_DATA_WIDTH-1:0] i_mem_data,
  input  logic [N_CH*NB_BER-1:0]     i_ber_samples,
  input  logic [N_CH*NB_BER-1:0]     i_ber_errors,
  output logic                       o_cmd_err
);
  localparam int EN_BIT = NB_GPIOS - CMD_W - 1;
  localparam int F_W = NB_GPIOS - 1;
  localparam int MC_W = $clog2(MEM_LAT + 1);
  localparam int RC_W = $clog2(RST_LEN + 1);
  state_t state;
  logic pulse, pend_v, ch_ok, legal, rd, unused_bits;
  logic [F_W-1:0] in_f, cur_f, pend_f;
  logic [CMD_W-1:0] cmd;
  logic [EN_BIT-1:0] d;
  logic [CH_W-1:0] ch, ch_sel;
  logic [MC_W-1:0] mem_cnt;
  logic [RC_W-1:0] rst_cnt;
  logic [NB_BER-1:0] shadow, err_live, err_src, ber_cap;
  logic [NB_GPIOS-1:0] gpi_nxt;
  gpio_edge_sync u_sync (.clk(clk100), .rst_n(i_resetn), .d(i_gpo[EN_BIT]), .pulse(pulse));
  assign in_f = {i_gpo[NB_GPIOS-1 -: CMD_W], i_gpo[EN_BIT-1:0]};
  assign cmd = cur_f[F_W-1 -: CMD_W];
  assign d = cur_f[EN_BIT-1:0];
  assign unused_bits = ^d;
  assign ch = d[CH_W-1:0];
  assign ch_ok = 32'(ch) < N_CH;
  assign ch_sel = ch_ok ? ch : '0;
  assign err_live = i_ber_errors[ch_sel*NB_BER +: NB_BER];
`ifdef GPIO_CMD_SNAPSHOT_EN
  logic snap_v;
  logic [CH_W-1:0] snap_ch;
  logic [NB_BER-1:0] snap_err;
  assign err_src = (snap_v && snap_ch == ch) ? snap_err : err_live;
  always_ff @(posedge clk100 or negedge i_resetn)
    if (!i_resetn) begin
      snap_v <= 1'b0;
      snap_ch <= '0;
      snap_err <= '0;
    end else if (state == ST_EXEC && ch_ok && cmd == CMD_BER_S) begin
      snap_v <= 1'b1;
      snap_ch <= ch;
      snap_err <= err_live;
    end else if (state == ST_EXEC && ch_ok && cmd == CMD_BER_E) snap_v <= 1'b0;
`else
  assign err_src = err_live;
`endif
  assign ber_cap = cmd == CMD_BER_S ? i_ber_samples[ch_sel*NB_BER +: NB_BER] : err_src;
  assign rd = cmd == CMD_ADDR_MEM && o_read_log;
  assign legal = cmd <= CMD_STATUS && (!(cmd == CMD_BER_S || cmd == CMD_BER_E) || ch_ok)
               && (cmd != CMD_ADDR_MEM || o_read_log);
  assign gpi_nxt = !legal ? '0
                 : (cmd == CMD_BER_S || cmd == CMD_BER_E) ? NB_GPIOS'(ber_cap)
                 : cmd == CMD_BER_H ? NB_GPIOS'({{NB_GPIOS{1'b0}}, shadow} >> NB_GPIOS)
                 : cmd == CMD_IS_MEM_FULL ? NB_GPIOS'(i_mem_full)
                 : cmd == CMD_STATUS ? NB_GPIOS'({i_mem_full, o_read_log, o_en_rx, o_en_tx, o_cmd_err})
                 : o_gpi;
  always_ff @(posedge clk100 or negedge i_resetn)
    if (!i_resetn) begin
      state <= ST_IDLE;
      cur_f <= '0;
      pend_f <= '0;
      pend_v <= 1'b0;
      mem_cnt <= '0;
      rst_cnt <= '0;
      shadow <= '0;
      o_gpi <= '0;
      o_rst <= 1'b0;
      o_en_tx <= 1'b0;
      o_en_rx <= 1'b0;
      o_phase_sel <= '0;
      o_run_log <= 1'b0;
      o_read_log <= 1'b0;
      o_addr_log <= '0;
      o_cmd_err <= 1'b0;
    end else begin
      o_run_log <= 1'b0;
      if (rst_cnt != '0) rst_cnt <= rst_cnt - RC_W'(1);
      else o_rst <= 1'b0;
      case (state)
        ST_IDLE:
          if (pend_v) begin
            cur_f <= pend_f;
            pend_v <= 1'b0;
            state <= ST_EXEC;
          end else if (pulse) begin
            cur_f <= in_f;
            state <= ST_EXEC;
          end
        ST_EXEC: begin
          o_cmd_err <= !legal;
          o_gpi <= gpi_nxt;
          mem_cnt <= '0;
          state <= (legal && rd) ? ST_MEM_WAIT : ST_IDLE;
          if (legal && cmd == CMD_RESET) begin
            o_rst <= 1'b1;
            rst_cnt <= RC_W'(RST_LEN - 1);
            o_en_tx <= 1'b0;
            o_en_rx <= 1'b0;
            o_read_log <= 1'b0;
            pend_v <= 1'b0;
          end
          if (legal && cmd == CMD_EN_TX) o_en_tx <= d[0];
          if (legal && cmd == CMD_EN_RX) o_en_rx <= d[0];
          if (legal && cmd == CMD_PH_SEL) o_phase_sel <= d[NB_PHASE-1:0];
          if (legal && cmd == CMD_RUN_MEM) begin
            o_run_log <= 1'b1;
            o_read_log <= 1'b0;
          end
          if (legal && cmd == CMD_READ_MEM) o_read_log <= d[0];
          if (cmd == CMD_ADDR_MEM) o_addr_log <= d[BRAM_ADDR_WIDTH-1:0];
          if (legal && (cmd == CMD_BER_S || cmd == CMD_BER_E)) shadow <= ber_cap;
        end
        ST_MEM_WAIT:
          if (mem_cnt == MC_W'(MEM_LAT - 1)) state <= ST_RESP;
          else mem_cnt <= mem_cnt + MC_W'(1);
        ST_RESP: begin
          o_gpi <= NB_GPIOS'(i_mem_data);
          if (pend_v) begin
            cur_f <= pend_f;
            pend_v <= 1'b0;
            state <= ST_EXEC;
          end else state <= ST_IDLE;
        end
      endcase
      // an edge that cannot start at once is parked; a second one while the slot is occupied is lost
      if (pulse && (state != ST_IDLE || pend_v)) begin
        if (pend_v) o_cmd_err <= 1'b1;
        else begin
          pend_f <= in_f;
          pend_v <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// tb_gpio_cmd_ctrl: directed self-checking bench for gpio_cmd_ctrl
module tb_gpio_cmd_ctrl;
  import gpio_cmd_pkg::*;
  logic clk100 = 1'b0;
  logic i_resetn = 1'b0;
  logic [31:0] i_gpo = '0;
  logic [31:0] o_gpi;
  logic o_rst, o_en_tx, o_en_rx, o_run_log, o_read_log, o_cmd_err;
  logic [1:0] o_phase_sel;
  logic [14:0] o_addr_log;
  logic i_mem_full = 1'b0;
  logic [15:0] i_mem_data, m1 = '0, m2 = '0;
  logic [127:0] i_ber_samples = '0;
  logic [127:0] i_ber_errors = '0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] seq [7];
  always #5 clk100 = ~clk100;
  always @(posedge clk100) begin
    m1 <= {1'b0, o_addr_log} ^ 16'hFFFF;
    m2 <= m1;
  end
  assign i_mem_data = m2;
  gpio_cmd_ctrl dut (
    .clk100(clk100), .i_resetn(i_resetn), .i_gpo(i_gpo), .o_gpi(o_gpi), .o_rst(o_rst),
    .o_en_tx(o_en_tx), .o_en_rx(o_en_rx), .o_phase_sel(o_phase_sel), .o_run_log(o_run_log),
    .o_read_log(o_read_log), .o_addr_log(o_addr_log), .i_mem_full(i_mem_full),
    .i_mem_data(i_mem_data), .i_ber_samples(i_ber_samples), .i_ber_errors(i_ber_errors),
    .o_cmd_err(o_cmd_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk100);
    #1;
  endtask
  // enable low for a cycle, then the word with enable high for n cycles; returns in cycle n after the rise
  task automatic issue(input logic [7:0] c, input logic [22:0] d, input int n);
    i_gpo[23] = 1'b0;
    step();
    i_gpo = {c, 1'b1, d};
    repeat (n) step();
    i_gpo[23] = 1'b0;
  endtask
  initial begin
    repeat (3) step();
    i_resetn = 1'b1;
    step();
    check("rst_gpi", o_gpi, 0);
    check("rst_orst", o_rst, 0);
    check("rst_en", {o_en_tx, o_en_rx, o_run_log, o_read_log, o_cmd_err}, 0);
    check("rst_phase", o_phase_sel, 0);
    check("rst_addr", o_addr_log, 0);
    issue(CMD_STATUS, 0, 4);
    check("status0", o_gpi, 0);
    issue(CMD_EN_TX, 1, 4);
    check("en_tx", o_en_tx, 1);
    issue(CMD_EN_RX, 1, 4);
    check("en_rx", o_en_rx, 1);
    issue(CMD_STATUS, 0, 4);
    check("status6", o_gpi, 32'h6);
    issue(CMD_PH_SEL, 3, 3);
    check("phase_e", o_phase_sel, 0);
    step();
    check("phase_e1", o_phase_sel, 3);
    issue(CMD_PH_SEL, 1, 4);
    check("phase1", o_phase_sel, 1);
    issue(CMD_RESET, 0, 3);
    check("orst_e", o_rst, 0);
    for (int i = 4; i <= 8; i++) begin
      step();
      check($sformatf("orst_c%0d", i), o_rst, i <= 7);
    end
    check("reset_en", {o_en_tx, o_en_rx}, 0);
    check("reset_phase", o_phase_sel, 1);
    i_gpo = '0;
    step();
    // second RESET edge two cycles after the first restarts the pulse count
    for (int i = 0; i < 4; i++) begin
      i_gpo = {CMD_RESET, ~i[0], 23'd0};
      step();
    end
    i_gpo = '0;
    for (int i = 4; i <= 10; i++) begin
      check($sformatf("orst_restart_c%0d", i), o_rst, i <= 9);
      step();
    end
    i_ber_samples = {64'h0000_0002_0000_0005, 64'h0};
    i_ber_errors = {64'h0, 64'h0000_0007_0000_0011};
    issue(CMD_BER_S, 1, 4);
    check("ber_s_lo", o_gpi, 32'h5);
    issue(CMD_BER_H, 0, 4);
    check("ber_h", o_gpi, 32'h2);
    issue(CMD_BER_S, 2, 4);
    check("ber_ch_bad_gpi", o_gpi, 0);
    check("ber_ch_bad_err", o_cmd_err, 1);
    issue(CMD_STATUS, 0, 4);
    check("status_err", o_gpi, 32'h1);
    check("status_clr", o_cmd_err, 0);
    issue(8'd12, 0, 4);
    check("bad_code_err", o_cmd_err, 1);
    issue(CMD_BER_E, 0, 4);
    check("ber_e_lo", o_gpi, 32'h11);
    check("ber_e_err", o_cmd_err, 0);
    issue(CMD_BER_H, 0, 4);
    check("ber_e_hi", o_gpi, 32'h7);
    i_mem_full = 1'b1;
    issue(CMD_IS_MEM_FULL, 0, 4);
    check("mem_full", o_gpi, 32'h1);
    i_mem_full = 1'b0;
    issue(CMD_READ_MEM, 1, 4);
    check("read_log", o_read_log, 1);
    issue(CMD_STATUS, 0, 4);
    check("status_rd", o_gpi, 32'h8);
    issue(CMD_ADDR_MEM, 23'h2A9C, 4);
    check("addr_e1", o_addr_log, 15'h2A9C);
    step();
    step();
    check("mem_e3", o_gpi, 32'h8);
    step();
    check("mem_e4", o_gpi, 32'hD563);
    issue(CMD_RUN_MEM, 0, 4);
    check("run_log", o_run_log, 1);
    check("run_rdlog", o_read_log, 0);
    step();
    check("run_log_off", o_run_log, 0);
    issue(CMD_ADDR_MEM, 23'h55, 4);
    check("addr_norl_err", o_cmd_err, 1);
    check("addr_norl_gpi", o_gpi, 0);
    issue(CMD_READ_MEM, 1, 4);
    step();
    // the data fields are sampled at each synchronised edge, two cycles after its enable rise
    seq = '{{CMD_ADDR_MEM, 1'b1, 23'h1234}, {CMD_ADDR_MEM, 1'b0, 23'h1234}, {CMD_ADDR_MEM, 1'b1, 23'h1234},
            {CMD_EN_TX, 1'b0, 23'd1}, {CMD_EN_TX, 1'b1, 23'd1}, {CMD_EN_RX, 1'b0, 23'd1}, {CMD_EN_RX, 1'b0, 23'd1}};
    for (int i = 0; i < 7; i++) begin
      i_gpo = seq[i];
      if (i == 4) check("pend_addr", o_addr_log, 15'h1234);
      step();
    end
    check("pend_resp", o_gpi, 32'hEDCB);
    check("pend_drop_err", o_cmd_err, 1);
    check("pend_tx_before", o_en_tx, 0);
    step();
    check("pend_tx_exec", o_en_tx, 1);
    check("pend_err_clr", o_cmd_err, 0);
    step();
    step();
    check("pend_rx_dropped", o_en_rx, 0);
    issue(CMD_ADDR_MEM, 23'h0F0F, 5);
    check("abort_pre", o_gpi, 32'hEDCB);
    i_resetn = 1'b0;
    #1;
    check("abort_gpi", o_gpi, 0);
    check("abort_ctl", {o_rst, o_en_tx, o_en_rx, o_run_log, o_read_log, o_cmd_err}, 0);
    check("abort_addr", o_addr_log, 0);
    step();
    step();
    i_resetn = 1'b1;
    repeat (4) step();
    check("abort_no_resp", o_gpi, 0);
    i_ber_errors = {64'h0, 64'hA};
    issue(CMD_BER_S, 0, 4);
    check("snap_s", o_gpi, 0);
    i_ber_errors = {64'h0, 64'hB};
    issue(CMD_BER_E, 0, 4);
`ifdef GPIO_CMD_SNAPSHOT_EN
    check("ber_e_snapshot", o_gpi, 32'hA);
`else
    check("ber_e_live", o_gpi, 32'hB);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
